// File: rtl/lasernet_pkg.sv
// Shared lasernet types: message buffer FSM states and default geometry.
// The CKSUM state exists only when MSGBUF_CHECKSUM_EN is defined.
package lasernet_pkg;

  localparam int DEFAULT_LOGSIZE = 8;
  localparam int DEFAULT_WIDTH   = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2
`ifdef MSGBUF_CHECKSUM_EN
    , CKSUM = 2'd3
`endif
  } state_t;

endpackage

// File: rtl/msgbuf_ram.sv
// Simple dual-port message storage: one write port, one read port with a
// registered (1-cycle) read, suitable for block-RAM inference.
module msgbuf_ram #(
  parameter int LOGSIZE = 8,
  parameter int WIDTH   = 64
) (
  input  logic               clk,
  input  logic               we,
  input  logic [LOGSIZE-1:0] waddr,
  input  logic [WIDTH-1:0]   wdata,
  input  logic [LOGSIZE-1:0] raddr,
  output logic [WIDTH-1:0]   rdata
);

  logic [WIDTH-1:0] mem [0:(1<<LOGSIZE)-1];

  // No reset here: contents and the output register survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/message_buffer.sv
// Append-only message buffer with random read and a ready/valid stream out.
// Define MSGBUF_CHECKSUM_EN to append an XOR checksum word to each stream.
module message_buffer
  import lasernet_pkg::*;
#(
  parameter int LOGSIZE = DEFAULT_LOGSIZE,
  parameter int WIDTH   = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               write,
  input  logic [WIDTH-1:0]   din,
  input  logic               clear,
  input  logic [LOGSIZE-1:0] readaddr,
  output logic [WIDTH-1:0]   dout,
  output logic [LOGSIZE-1:0] maxaddr,
  output logic               full,
  output logic               overflow,
  input  logic               start,
  output logic [WIDTH-1:0]   tx_data,
  output logic               tx_valid,
  output logic               tx_last,
  input  logic               tx_ready,
  output logic               busy
);

  localparam logic [LOGSIZE-1:0] TOP_ADDR = '1;

  state_t             state_reg, state_next;
  logic [LOGSIZE-1:0] maxaddr_reg;
  logic               overflow_reg;
  logic [LOGSIZE-1:0] ptr_reg, ptr_next;
  logic               hdr_sel_reg;
  logic [LOGSIZE-1:0] hdr_val_reg;
  logic [WIDTH-1:0]   ram_rdata;
  logic [LOGSIZE-1:0] ram_raddr;
  logic               accept_write;
  logic               drop_write;

  assign maxaddr  = maxaddr_reg;
  assign overflow = overflow_reg;
  assign full     = (maxaddr_reg == TOP_ADDR);
  assign busy     = (state_reg != IDLE);

  assign accept_write = write && !clear && !busy && !full;
  assign drop_write   = write && !clear && (busy || full);

  // The stream owns the read port whenever the FSM is active.
  assign ram_raddr = busy ? ptr_reg : readaddr;

  msgbuf_ram #(
    .LOGSIZE(LOGSIZE),
    .WIDTH  (WIDTH)
  ) u_ram (
    .clk  (clk),
    .we   (accept_write),
    .waddr(maxaddr_reg + LOGSIZE'(1)),
    .wdata(din),
    .raddr(ram_raddr),
    .rdata(ram_rdata)
  );

  // Address 0 is the header: it reads back the word count, not RAM.
  assign dout = hdr_sel_reg ? {{(WIDTH-LOGSIZE){1'b0}}, hdr_val_reg} : ram_rdata;

`ifdef MSGBUF_CHECKSUM_EN
  logic [WIDTH-1:0] cksum_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cksum_reg <= '0;
    end else if (state_reg == IDLE) begin
      cksum_reg <= '0;
    end else if (state_reg == SEND && tx_ready) begin
      cksum_reg <= cksum_reg ^ ram_rdata;
    end
  end
`endif

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    tx_valid   = 1'b0;
    tx_last    = 1'b0;
    tx_data    = '0;
    case (state_reg)
      IDLE: begin
        if (start && maxaddr_reg != '0) begin
          state_next = FETCH;
          ptr_next   = LOGSIZE'(1);
        end
      end
      FETCH: state_next = SEND;
      SEND: begin
        tx_valid = 1'b1;
        tx_data  = ram_rdata;
`ifndef MSGBUF_CHECKSUM_EN
        tx_last  = (ptr_reg == maxaddr_reg);
`endif
        if (tx_ready) begin
          if (ptr_reg == maxaddr_reg) begin
`ifdef MSGBUF_CHECKSUM_EN
            state_next = CKSUM;
`else
            state_next = IDLE;
`endif
          end else begin
            ptr_next   = ptr_reg + LOGSIZE'(1);
            state_next = FETCH;
          end
        end
      end
`ifdef MSGBUF_CHECKSUM_EN
      CKSUM: begin
        tx_valid = 1'b1;
        tx_last  = 1'b1;
        tx_data  = cksum_reg;
        if (tx_ready) begin
          state_next = IDLE;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
    if (clear) begin
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      ptr_reg      <= '0;
      maxaddr_reg  <= '0;
      overflow_reg <= 1'b0;
      hdr_sel_reg  <= 1'b1;
      hdr_val_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      ptr_reg     <= ptr_next;
      hdr_sel_reg <= (readaddr == '0);
      hdr_val_reg <= maxaddr_reg;
      if (clear) begin
        maxaddr_reg  <= '0;
        overflow_reg <= 1'b0;
      end else begin
        if (accept_write) begin
          maxaddr_reg <= maxaddr_reg + LOGSIZE'(1);
        end
        if (drop_write) begin
          overflow_reg <= 1'b1;
        end
      end
    end
  end

endmodule
